fp2int: RTL and testbench
=========================

FP2INT -- requirements
Module: fp2int

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; sole clock of the block.
REQ-002 SHALL: rst  input  1  reset, asynchronous and active-low; all state clears while rst=0.
REQ-003 SHALL: pushin  input  1  high for one cycle per operand; operand a valid that cycle.
REQ-004 SHALL: a  input  64  operand in the team FP format: a[63] sign, a[62:52] exponent (bias 1023), a[51:0] fraction with implied leading 1; a[62:0]==0 is zero.
REQ-005 SHALL: pushout  output  1  high for one cycle when r/ovf carry a result.
REQ-006 SHALL: r  output  64  signed two's-complement integer result.
REQ-007 SHALL: ovf  output  1  result magnitude not representable in signed 64 bits.

Function
REQ-008 SHALL: convert a to int64 by truncation toward zero; no NaN/infinity/denormal handling.
REQ-009 SHALL: unbiased exponent ue = a[62:52]-1023; mantissa m = {1,a[51:0]} (53 bits).
REQ-010 SHALL: operand zero (a[62:0]==0) or ue<0 -> r=0, ovf=0, regardless of sign (no -0).
REQ-011 SHALL: 0<=ue<=52 -> magnitude = m >> (52-ue); 52<ue<=62 -> magnitude = m << (ue-52).
REQ-012 SHALL: sign=1 -> r = two's-complement negation of magnitude; sign=0 -> r = magnitude.
REQ-013 SHALL: ue>63, or ue==63 with sign=0, or ue==63 with sign=1 and a[51:0]!=0 -> ovf=1 (r per REQ-022).
REQ-014 SHALL: ue==63, sign=1, a[51:0]==0 -> r=0x8000_0000_0000_0000, ovf=0 (exact -2^63).
REQ-015 SHALL: 3-stage pipeline: S1 unpack/classify/shift count, S2 barrel shift, S3 negate/overflow select into output regs.
REQ-016 SHALL: pushout asserts exactly 3 clk edges after the edge sampling pushin=1; latency fixed.
REQ-017 SHALL: accept one operand per cycle; back-to-back pushin yields back-to-back pushout, in order.
REQ-018 SHALL: valid bit shifts every cycle; data registers of a stage load only when that stage's incoming valid=1, else hold.
REQ-019 SHALL: r and ovf hold last result while pushout=0; no backpressure input exists.
REQ-020 SHALL: pushin gaps of any length produce matching pushout gaps; no result is dropped or duplicated.

Reset
REQ-021 SHALL: rst=0 clears pushout=0, r=0, ovf=0 and every pipeline valid/data register, immediately and asynchronously; in-flight operands are discarded, and the first pushin after rst=1 returns after 3 cycles.

Configuration
REQ-022 SHALL: macro FP2INT_SAT_EN defined -> on ovf=1, r = 0x7FFF_FFFF_FFFF_FFFF if sign=0, 0x8000_0000_0000_0000 if sign=1.
REQ-023 SHALL: FP2INT_SAT_EN undefined -> on ovf=1, r = 0x8000_0000_0000_0000 for either sign; ovf flag behaviour identical in both builds.

Verification
REQ-024 SHALL: pushin with a=0x3FF0_0000_0000_0000 (1.0) -> 3 cycles later pushout=1, r=0x0000_0000_0000_0001, ovf=0.
REQ-025 SHALL: a=0xC004_0000_0000_0000 (-2.5) -> r=0xFFFF_FFFF_FFFF_FFFE; a=0x3FE0_0000_0000_0000 (0.5) -> r=0; a=0x8000_0000_0000_0000 -> r=0.
REQ-026 SHALL: a=0x43E0_0000_0000_0000 (+2^63) -> ovf=1, r=0x7FFF_FFFF_FFFF_FFFF with FP2INT_SAT_EN, 0x8000_0000_0000_0000 without; a=0xC3E0_0000_0000_0000 -> r=0x8000_0000_0000_0000, ovf=0.
REQ-027 SHALL: a=0x4330_0000_0000_0001 (2^52+1) -> r=0x0010_0000_0000_0001; a=0x43DF_FFFF_FFFF_FFFF -> r=0x7FFF_FFFF_FFFF_FC00.
REQ-028 SHALL: 5 consecutive pushin cycles (1.0, 2.0, 3.0, -1.0, 0.0) -> 5 consecutive pushout cycles r=1,2,3,0xFFFF_FFFF_FFFF_FFFF,0 in order.
REQ-029 SHALL: rst=0 asserted asynchronously (between clk edges) with 2 operands in flight -> pushout, r and ovf reach 0 before the next clk edge, no pushout for discarded operands, next operand after release returns with latency 3.

Source files
------------

// File: rtl/fp2int.sv
// Team-FP (sign/11-bit exponent/52-bit fraction) to int64 converter, truncating toward zero.
// 3-cycle fixed latency, one operand per cycle, no backpressure; FP2INT_SAT_EN selects signed saturation on overflow.
module fp2int (
   input  logic        clk,
   input  logic        rst,
   input  logic        pushin,
   input  logic [63:0] a,
   output logic        pushout,
   output logic [63:0] r,
   output logic        ovf
);

   localparam logic [10:0] EXP_BIAS = 11'd1023;  // ue = 0
   localparam logic [10:0] EXP_INT  = 11'd1075;  // ue = 52, no shift needed
   localparam logic [10:0] EXP_MAX  = 11'd1086;  // ue = 63

   // ---------------- S1: unpack, classify, shift count ----------------
   logic        c_zero;
   logic        c_ovf;
   logic        c_left;
   logic [5:0]  c_sh;

   logic        s1_vld;
   logic        s1_sign;
   logic        s1_zero;
   logic        s1_ovf;
   logic        s1_left;
   logic [5:0]  s1_sh;
   logic [52:0] s1_m;

   always_comb begin
      c_zero = (a[62:0] == 63'd0) || (a[62:52] < EXP_BIAS);
      // -2^63 is the only ue==63 value that fits; everything else at or above ue==63 overflows
      c_ovf  = !c_zero && ((a[62:52] > EXP_MAX) ||
                           ((a[62:52] == EXP_MAX) && !(a[63] && (a[51:0] == 52'd0))));
      c_left = a[62:52] > EXP_INT;
      // 1075 mod 64 == 51, so the useful shift counts come straight from the low exponent bits
      c_sh   = c_left ? (a[57:52] - 6'd51) : (6'd51 - a[57:52]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_ovf  <= 1'b0;
         s1_left <= 1'b0;
         s1_sh   <= '0;
         s1_m    <= '0;
      end else begin
         s1_vld <= pushin;
         if (pushin) begin
            s1_sign <= a[63];
            s1_zero <= c_zero;
            s1_ovf  <= c_ovf;
            s1_left <= c_left;
            s1_sh   <= c_sh;
            s1_m    <= {1'b1, a[51:0]};
         end
      end
   end

   // ---------------- S2: barrel shift ----------------
   logic [63:0] m_ext;
   logic [63:0] c_mag;

   logic        s2_vld;
   logic        s2_sign;
   logic        s2_ovf;
   logic [63:0] s2_mag;

   always_comb begin
      m_ext = {11'd0, s1_m};
      if (s1_zero)
         c_mag = '0;
      else if (s1_left)
         c_mag = m_ext << s1_sh;
      else
         c_mag = m_ext >> s1_sh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_vld  <= 1'b0;
         s2_sign <= 1'b0;
         s2_ovf  <= 1'b0;
         s2_mag  <= '0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_sign <= s1_sign;
            s2_ovf  <= s1_ovf;
            s2_mag  <= c_mag;
         end
      end
   end

   // ---------------- S3: negate / overflow select ----------------
   logic [63:0] sat_val;
   logic [63:0] c_r;

   always_comb begin
`ifdef FP2INT_SAT_EN
      sat_val = s2_sign ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`else
      sat_val = 64'h8000_0000_0000_0000;
`endif
      if (s2_ovf)
         c_r = sat_val;
      else if (s2_sign)
         c_r = -s2_mag;
      else
         c_r = s2_mag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pushout <= 1'b0;
         r       <= '0;
         ovf     <= 1'b0;
      end else begin
         pushout <= s2_vld;
         if (s2_vld) begin
            r   <= c_r;
            ovf <= s2_ovf;
         end
      end
   end

endmodule

// File: tb/tb_fp2int.sv
// Directed bench for fp2int: reset, conversions, overflow/saturation, streaming, gaps, async reset.
module tb_fp2int;

   logic        clk;
   logic        rst;
   logic        pushin;
   logic [63:0] a;
   logic        pushout;
   logic [63:0] r;
   logic        ovf;

   int tests = 0;
   int fails = 0;

`ifdef FP2INT_SAT_EN
   localparam logic [63:0] POS_OVF_R = 64'h7FFF_FFFF_FFFF_FFFF;
`else
   localparam logic [63:0] POS_OVF_R = 64'h8000_0000_0000_0000;
`endif

   fp2int dut (
      .clk(clk), .rst(rst), .pushin(pushin), .a(a),
      .pushout(pushout), .r(r), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operand at a negedge and waits (bounded) for its result.
   task automatic convert(input logic [63:0] av, output logic [63:0] got_r,
                          output logic got_ovf, output int lat);
      @(negedge clk);
      pushin = 1'b1;
      a      = av;
      lat     = 0;
      got_r   = '0;
      got_ovf = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         pushin = 1'b0;
         if (pushout) begin
            lat     = k;
            got_r   = r;
            got_ovf = ovf;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; pushin = 1'b0; a = '0;
      #1;
      tests++;
      if (pushout !== 1'b0) begin fails++; $display("FAIL reset_pushout: got %b want 0", pushout); end
      tests++;
      if (r !== 64'd0) begin fails++; $display("FAIL reset_r: got %h want 0", r); end
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [63:0] va [7];
      logic [63:0] er [7];
      logic [63:0] gr;
      logic        go;
      int          lat;
      va = '{64'h3FF0_0000_0000_0000, 64'hC004_0000_0000_0000, 64'h3FE0_0000_0000_0000,
             64'h8000_0000_0000_0000, 64'h3FF8_0000_0000_0000, 64'hBFF8_0000_0000_0000,
             64'h0000_0000_0000_0000};
      er = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0000,
             64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0000_0000_0000_0000};
      for (int i = 0; i < 7; i++) begin
         convert(va[i], gr, go, lat);
         tests++;
         if (gr !== er[i] || go !== 1'b0 || lat != 3) begin
            fails++;
            $display("FAIL basic[%0d] a=%h: r=%h ovf=%b lat=%0d, want r=%h ovf=0 lat=3",
                     i, va[i], gr, go, lat, er[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [63:0] va [6];
      logic [63:0] er [6];
      logic        eo [6];
      logic [63:0] gr;
      logic        go;
      int          lat;
      va = '{64'h43E0_0000_0000_0000, 64'hC3E0_0000_0000_0000, 64'hC3E0_0000_0000_0001,
             64'h4400_0000_0000_0000, 64'hC400_0000_0000_0000, 64'h43E8_0000_0000_0000};
      er = '{POS_OVF_R, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             POS_OVF_R, 64'h8000_0000_0000_0000, POS_OVF_R};
      eo = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         convert(va[i], gr, go, lat);
         tests++;
         if (gr !== er[i] || go !== eo[i] || lat != 3) begin
            fails++;
            $display("FAIL overflow[%0d] a=%h: r=%h ovf=%b lat=%0d, want r=%h ovf=%b lat=3",
                     i, va[i], gr, go, lat, er[i], eo[i]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [63:0] va [4];
      logic [63:0] er [4];
      logic [63:0] gr;
      logic        go;
      int          lat;
      va = '{64'h4330_0000_0000_0001, 64'h43DF_FFFF_FFFF_FFFF,
             64'hC3DF_FFFF_FFFF_FFFF, 64'h4330_0000_0000_0000};
      er = '{64'h0010_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FC00,
             64'h8000_0000_0000_0400, 64'h0010_0000_0000_0000};
      for (int i = 0; i < 4; i++) begin
         convert(va[i], gr, go, lat);
         tests++;
         if (gr !== er[i] || go !== 1'b0 || lat != 3) begin
            fails++;
            $display("FAIL boundary[%0d] a=%h: r=%h ovf=%b lat=%0d, want r=%h ovf=0 lat=3",
                     i, va[i], gr, go, lat, er[i]);
         end
      end
      // outputs must hold while idle
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (pushout !== 1'b0 || r !== 64'h0010_0000_0000_0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL hold[%0d]: pushout=%b r=%h ovf=%b, want 0/0010000000000000/0",
                     k, pushout, r, ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] va [5];
      logic [63:0] er [5];
      logic [63:0] got [$];
      int          idx [$];
      va = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
             64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000};
      er = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (pushout) begin got.push_back(r); idx.push_back(k); end
         pushin = (k < 5);
         a      = (k < 5) ? va[k] : 64'd0;
      end
      tests++;
      if (got.size() != 5) begin
         fails++;
         $display("FAIL b2b_count: got %0d results, want 5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (got[i] !== er[i] || idx[i] != i + 3) begin
               fails++;
               $display("FAIL b2b[%0d]: r=%h at step %0d, want r=%h at step %0d",
                        i, got[i], idx[i], er[i], i + 3);
            end
         end
      end
   endtask

   task automatic test_gaps();
      logic        pin [12];
      logic [63:0] va  [12];
      logic [63:0] er  [4];
      int          es  [4];
      logic [63:0] got [$];
      int          idx [$];
      pin = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      va  = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
              64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000,
              64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000, 64'hBFF0_0000_0000_0000,
              64'h0, 64'h0, 64'h0};
      er  = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
      es  = '{3, 6, 7, 11};
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (pushout) begin got.push_back(r); idx.push_back(k); end
         pushin = (k < 12) ? pin[k] : 1'b0;
         a      = (k < 12) ? va[k] : 64'd0;
      end
      tests++;
      if (got.size() != 4) begin
         fails++;
         $display("FAIL gap_count: got %0d results, want 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== er[i] || idx[i] != es[i]) begin
               fails++;
               $display("FAIL gap[%0d]: r=%h at step %0d, want r=%h at step %0d",
                        i, got[i], idx[i], er[i], es[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [63:0] gr;
      logic        go;
      int          lat;
      int          stray;
      @(negedge clk); pushin = 1'b1; a = 64'h3FF0_0000_0000_0000;
      @(negedge clk); a = 64'h4000_0000_0000_0000;
      @(negedge clk); pushin = 1'b0; a = 64'd0;
      #2 rst = 1'b0;
      #1;
      tests++;
      if (pushout !== 1'b0 || r !== 64'd0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL async_clear: pushout=%b r=%h ovf=%b, want 0/0/0", pushout, r, ovf);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (pushout) stray++;
      end
      tests++;
      if (stray != 0) begin
         fails++;
         $display("FAIL async_discard: %0d stray pushouts, want 0", stray);
      end
      convert(64'h4008_0000_0000_0000, gr, go, lat);
      tests++;
      if (gr !== 64'd3 || go !== 1'b0 || lat != 3) begin
         fails++;
         $display("FAIL async_restart: r=%h ovf=%b lat=%0d, want r=3 ovf=0 lat=3", gr, go, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_boundary();
      test_back_to_back();
      test_gaps();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
